// File: rtl/hs32_regfile_banked.sv
// Banked register file: main bank of 2^AW entries plus a shadow bank for entries 0..NBANK-1,
// byte-enable writes, registered reads with write bypass, and a clear sweep after reset or on request.
module hs32_regfile_banked #(
    parameter int DW    = 32,
    parameter int AW    = 4,
    parameter int NBANK = 8,
    parameter int NRP   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                banksel_i,
    input  logic [AW-1:0]       wp_addr_i,
    input  logic [DW-1:0]       wp_data_i,
    input  logic [DW/8-1:0]     wp_be_i,
    input  logic                wp_we1_i,
    input  logic                wp_we2_i,
    input  logic [NRP*AW-1:0]   rp_addr_i,
    output logic [NRP*DW-1:0]   rp_data_o,
    input  logic                clr_i,
    output logic                ready_o
);

    localparam int NE = 1 << AW;
    localparam int NBYTE = DW / 8;
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam logic [AW:0] NBANK_L = (AW+1)'(NBANK);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       main_q  [NE];
    logic [DW-1:0]       main_d  [NE];
    logic [DW-1:0]       bank2_q [NBANK];
    logic [DW-1:0]       bank2_d [NBANK];
    logic [NRP*DW-1:0]   rp_data_q, rp_data_d;

    function automatic logic in_window(input logic [AW-1:0] a);
        return {1'b0, a} < NBANK_L;
    endfunction

    function automatic logic [BW-1:0] b2_idx(input logic [AW-1:0] a);
        return a[BW-1:0];
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [NBYTE-1:0] be);
        logic [DW-1:0] r;
        r = old_v;
        for (int unsigned k = 0; k < NBYTE; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == '1) state_d = ST_READY;
            end
            ST_READY: begin
                if (clr_i) begin
                    idx_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // A clear request in READY takes priority over a write presented in the same cycle.
    always_comb begin
        main_d  = main_q;
        bank2_d = bank2_q;
        if (state_q == ST_CLEAR) begin
            main_d[idx_q] = '0;
            if (in_window(idx_q)) bank2_d[b2_idx(idx_q)] = '0;
        end else if (!clr_i) begin
            if (wp_we1_i)
                main_d[wp_addr_i] = merge(main_q[wp_addr_i], wp_data_i, wp_be_i);
            if (wp_we2_i && in_window(wp_addr_i))
                bank2_d[b2_idx(wp_addr_i)] = merge(bank2_q[b2_idx(wp_addr_i)], wp_data_i, wp_be_i);
        end
    end

    // Reading the next-state arrays gives the bypassed, byte-merged value for free.
    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rp_data_d = '0;
        if (state_q == ST_READY && !clr_i) begin
            for (int unsigned p = 0; p < NRP; p++) begin
                ra = rp_addr_i[p*AW +: AW];
                rp_data_d[p*DW +: DW] = (banksel_i && in_window(ra)) ? bank2_d[b2_idx(ra)]
                                                                     : main_d[ra];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            idx_q     <= '0;
            rp_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rp_data_q <= rp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        main_q  <= main_d;
        bank2_q <= bank2_d;
    end

    assign rp_data_o = rp_data_q;
    assign ready_o   = (state_q == ST_READY);

endmodule
